spi_fwm_sram_arb: RTL and testbench
===================================

# spi_fwm_sram_arb

Round-robin arbiter that shares the single-port SPI firmware-mode buffer SRAM between N requesters: the RX FIFO controller, the TX FIFO controller and the register-bus SRAM window. It forwards one request per cycle to the SRAM and tracks the requester ID of every outstanding read. Each read response (rvalid/rdata/error) is returned only to the requester that issued it. It sits between the firmware-mode controllers and the SRAM macro wrapper.

## Interface
- NumReq, default 3: number of requesters; index 0 = RXF, 1 = TXF, 2 = bus window.
- SramAw, default 11: SRAM word-address width.
- SramDw, default 32: SRAM data width.
- MaxOutRd, default 2: maximum outstanding reads, which is also the ID FIFO depth; must be a power of two and at least 1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumReq  per-requester request.
- write_i  in  NumReq  per-requester write (1) / read (0).
- addr_i  in  NumReq*SramAw  packed addresses; requester k at [k*SramAw +: SramAw].
- wdata_i  in  NumReq*SramDw  packed write data.
- gnt_o  out  NumReq  one-hot grant.
- rvalid_o  out  NumReq  one-hot read-data valid.
- rdata_o  out  SramDw  read data, broadcast to all requesters.
- rerror_o  out  2  read error, broadcast to all requesters.
- sram_req_o  out  1  SRAM request.
- sram_write_o  out  1  SRAM write.
- sram_addr_o  out  SramAw  SRAM address.
- sram_wdata_o  out  SramDw  SRAM write data.
- sram_gnt_i  in  1  SRAM grant.
- sram_rvalid_i  in  1  SRAM read valid; asserted only for reads.
- sram_rdata_i  in  SramDw  SRAM read data.
- sram_error_i  in  2  SRAM error.
- unexp_rvalid_o  out  1  one-cycle pulse when sram_rvalid_i arrives while no read is outstanding.

## Operation
- Requester protocol: once req_i[k] is asserted, the requester holds req_i[k], write_i[k], addr_i and wdata_i stable until gnt_o[k] is seen. One transfer completes per grant.
- Eligibility:
  - Requester k is eligible when req_i[k] = 1.
  - A read is eligible only if the ID FIFO is not full (registered count < MaxOutRd).
  - Writes are never blocked.
- Arbitration:
  - Round-robin over eligible requesters, starting the search at the priority pointer prio_q.
  - The winner's write/addr/wdata are muxed to the SRAM port.
  - sram_req_o = 1 whenever any requester is eligible.
- Lock: if the winner is not granted (sram_gnt_i = 0), lock_q holds the same winner in later cycles until it is granted. A newly eligible requester cannot pre-empt a pending, ungranted request.
- Grant:
  - gnt_o[w] = sram_gnt_i & sram_req_o for winner w; all other bits are 0.
  - On grant, prio_q <= (w+1) mod NumReq and the lock is released.
- Read tracking:
  - A granted read pushes w into the ID FIFO.
  - Each sram_rvalid_i pops the head ID h; rvalid_o[h] = 1, and rdata_o and rerror_o pass through from the SRAM.
  - Push and pop in the same cycle leave the count unchanged; this is legal even when the FIFO is full.
- Empty pop: sram_rvalid_i while the FIFO is empty drives rvalid_o = 0 and unexp_rvalid_o = 1; FIFO state is unchanged.
- Writes: produce no response and are not tracked.

## Timing
- Request path is combinational: req_i/addr_i reach sram_*_o in the same cycle. gnt_o follows sram_gnt_i combinationally. Zero added latency.
- Response path is combinational: rvalid_o follows sram_rvalid_i in the same cycle. Read latency seen by a requester equals the SRAM read latency.
- State registers: prio_q, lock_q plus locked index, ID FIFO pointers and count.
- Reset values:
  - Registers: prio_q = 0, no lock, FIFO empty.
  - Outputs with all inputs at 0: gnt_o = 0, rvalid_o = 0, sram_req_o = 0, unexp_rvalid_o = 0.
- Reset mid-operation discards all outstanding IDs. Any rvalid arriving after reset is reported through unexp_rvalid_o.
- Full boundary: with count = MaxOutRd, a pending read is masked. A write from another requester may win in that cycle. The read becomes eligible in the cycle after a pop reduces the count; the full check is on the registered count, not same-cycle.

## Structure
- Shared package spi_device_pkg holds the requester index constants (SramReqRxf = 0, SramReqTxf = 1, SramReqBus = 2) and the default SramAw/SramDw.
- The read-ID FIFO is one natural sub-module: spi_fwm_rid_fifo.
  - Parameters: width $clog2(NumReq), depth MaxOutRd.
  - Ports: push/pop/wdata/rdata/full/empty.
- Arbitration and lock logic stay in this module.

## Test plan
- Single read: req_i = 3'b001, write_i = 0, addr = 0x10, SRAM grants immediately with rvalid 1 cycle later and rdata = 0xA5A5_0001 → gnt_o = 001 in cycle 0; rvalid_o = 001 and rdata_o = 0xA5A5_0001 in cycle 1.
- Round-robin: all three requesters hold writes, sram_gnt_i always 1 → grants in order 001, 010, 100, 001.
- Lock: req 0 read with sram_gnt_i = 0 for 3 cycles, req 1 asserts in cycle 1 → sram_addr_o stays at req 0's address; gnt_o = 001 when the grant arrives; req 1 is granted next.
- Full blocking (MaxOutRd = 2): two granted reads with no rvalid, then req 2 read plus req 1 write → req 1 write is granted and req 2 is not. After one rvalid (routed to the first reader), req 2 is granted the following cycle.
- Response ordering: reads from req 2 then req 0, with rvalids back-to-back → rvalid_o = 100 then 001.
- Unexpected rvalid and reset: assert sram_rvalid_i with the FIFO empty → unexp_rvalid_o pulses and rvalid_o = 0. Assert rst_ni low with 1 read outstanding, then rvalid → also flagged unexpected.

Source files
------------

// File: rtl/spi_device_pkg.sv
// spi_device_pkg: shared SPI device constants for the firmware-mode SRAM arbiter
package spi_device_pkg;
  localparam int SramReqRxf = 0;
  localparam int SramReqTxf = 1;
  localparam int SramReqBus = 2;
  localparam int SramAwDefault = 11;
  localparam int SramDwDefault = 32;
endpackage

// File: rtl/spi_fwm_rid_fifo.sv
// spi_fwm_rid_fifo: requester-ID FIFO for outstanding SRAM reads
module spi_fwm_rid_fifo #(
  parameter int Width = 2,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (int'(p) == Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == CntW'(Depth);
  assign empty = cnt == '0;
  assign rdata = mem[rptr];
  assign do_pop = pop & ~empty;
  // a pop frees the head slot before the edge, so push-while-full is safe then
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop) rptr <= inc(rptr);
      cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/spi_fwm_sram_arb.sv
// spi_fwm_sram_arb: round-robin sharing of the firmware-mode buffer SRAM with read-ID routing
module spi_fwm_sram_arb
  import spi_device_pkg::*;
#(
  parameter int NumReq = 3,
  parameter int SramAw = SramAwDefault,
  parameter int SramDw = SramDwDefault,
  parameter int MaxOutRd = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        write_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*SramDw-1:0] wdata_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [SramDw-1:0]        rdata_o,
  output logic [1:0]               rerror_o,
  output logic                     sram_req_o,
  output logic                     sram_write_o,
  output logic [SramAw-1:0]        sram_addr_o,
  output logic [SramDw-1:0]        sram_wdata_o,
  input  logic                     sram_gnt_i,
  input  logic                     sram_rvalid_i,
  input  logic [SramDw-1:0]        sram_rdata_i,
  input  logic [1:0]               sram_error_i,
  output logic                     unexp_rvalid_o
);
  localparam int IdW = NumReq > 1 ? $clog2(NumReq) : 1;
  logic [IdW-1:0] prio_q, lock_idx_q, win, win_rr, head;
  logic lock_q, found, full, empty, granted, push, pop;
  logic [NumReq-1:0] elig;
  assign elig = req_i & (write_i | {NumReq{~full}});
  always_comb begin
    found = 1'b0;
    win_rr = '0;
    for (int i = 0; i < NumReq; i++)
      if (!found && elig[(int'(prio_q) + i) % NumReq]) begin
        found = 1'b1;
        win_rr = IdW'((int'(prio_q) + i) % NumReq);
      end
  end
  // an ungranted winner keeps the port until the SRAM accepts it
  assign win = lock_q ? lock_idx_q : win_rr;
  assign sram_req_o = lock_q ? elig[win] : found;
  assign sram_write_o = write_i[win];
  assign sram_addr_o = addr_i[win*SramAw +: SramAw];
  assign sram_wdata_o = wdata_i[win*SramDw +: SramDw];
  assign granted = sram_req_o & sram_gnt_i;
  assign push = granted & ~write_i[win];
  assign pop = sram_rvalid_i & ~empty;
  assign unexp_rvalid_o = sram_rvalid_i & empty;
  assign rdata_o = sram_rdata_i;
  assign rerror_o = sram_error_i;
  always_comb begin
    gnt_o = '0;
    rvalid_o = '0;
    gnt_o[win] = granted;
    rvalid_o[head] = pop;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      prio_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (granted) begin
      prio_q <= (int'(win) == NumReq - 1) ? '0 : win + 1'b1;
      lock_q <= 1'b0;
    end else if (sram_req_o) begin
      lock_q <= 1'b1;
      lock_idx_q <= win;
    end
  spi_fwm_rid_fifo #(.Width(IdW), .Depth(MaxOutRd)) u_rid_fifo (
    .clk_i,
    .rst_ni,
    .push,
    .pop,
    .wdata(win),
    .rdata(head),
    .full,
    .empty
  );
endmodule

// File: tb/tb_spi_fwm_sram_arb.sv
// tb_spi_fwm_sram_arb: directed scoreboard bench for the firmware-mode SRAM arbiter
module tb_spi_fwm_sram_arb;
  localparam int N = 3;
  localparam int AW = 11;
  localparam int DW = 32;
  typedef struct packed {
    logic [N-1:0] rv;
    logic [DW-1:0] d;
    logic [1:0] e;
    logic u;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] req = '0, write = '0, gnt, rvalid;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, s_wdata, s_rdata = '0;
  logic [AW-1:0] s_addr;
  logic [1:0] rerror, s_err = '0;
  logic s_req, s_write, unexp, s_gnt = 1'b0, s_rvalid = 1'b0;
  logic [N-1:0] gq[$];
  rsp_t rq[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  spi_fwm_sram_arb #(.NumReq(N), .SramAw(AW), .SramDw(DW), .MaxOutRd(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .write_i(write), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rerror_o(rerror),
    .sram_req_o(s_req), .sram_write_o(s_write), .sram_addr_o(s_addr), .sram_wdata_o(s_wdata),
    .sram_gnt_i(s_gnt), .sram_rvalid_i(s_rvalid), .sram_rdata_i(s_rdata), .sram_error_i(s_err),
    .unexp_rvalid_o(unexp)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic rsp_t rsp(input logic [N-1:0] rv, input logic [DW-1:0] d, input logic [1:0] e, input logic u);
    return '{rv: rv, d: d, e: e, u: u};
  endfunction
  task automatic drv(input int k, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req[k] = r;
    write[k] = w;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = wd;
  endtask
  task automatic idle();
    req = '0;
    write = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    s_err = '0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {gnt, rvalid, s_req, unexp}, '0);
    cyc();
    rst_ni = 1'b1;
  endtask
  always @(negedge clk)
    if (rst_ni) begin
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL gnt_unexpected: got %b want none", gnt);
        end else chk("gnt", gnt, gq.pop_front());
      end
      if (rvalid != '0 || unexp) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rv=%b unexp=%b want none", rvalid, unexp);
        end else chk("rsp", {rvalid, rdata, rerror, unexp}, rq.pop_front());
      end
    end
  initial begin
    do_reset();
    // single read
    drv(0, 1, 0, 11'h10, '0);
    s_gnt = 1;
    gq.push_back(3'b001);
    @(negedge clk);
    chk("t1_addr", s_addr, 11'h10);
    cyc();
    idle();
    s_rvalid = 1;
    s_rdata = 32'hA5A5_0001;
    rq.push_back(rsp(3'b001, 32'hA5A5_0001, 2'b00, 0));
    cyc();
    idle();
    cyc();
    // round robin on writes
    do_reset();
    for (int k = 0; k < N; k++) drv(k, 1, 1, 11'(k + 4), 32'(k));
    s_gnt = 1;
    for (int c = 0; c < 4; c++) begin
      gq.push_back(3'b001 << (c % 3));
      @(negedge clk);
      chk("t2_wdata", s_wdata, 32'(c % 3));
      cyc();
    end
    idle();
    cyc();
    // lock holds winner while ungranted
    do_reset();
    drv(0, 1, 0, 11'h20, '0);
    cyc();
    drv(1, 1, 1, 11'h30, 32'h77);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_lock_addr", s_addr, 11'h20);
      cyc();
    end
    s_gnt = 1;
    gq.push_back(3'b001);
    @(negedge clk);
    chk("t3_gnt_addr", s_addr, 11'h20);
    cyc();
    req[0] = 0;
    gq.push_back(3'b010);
    @(negedge clk);
    chk("t3_next_addr", s_addr, 11'h30);
    cyc();
    idle();
    s_rvalid = 1;
    s_rdata = 32'h1234;
    s_err = 2'b10;
    rq.push_back(rsp(3'b001, 32'h1234, 2'b10, 0));
    cyc();
    idle();
    cyc();
    // full blocking
    do_reset();
    s_gnt = 1;
    drv(0, 1, 0, 11'h1, '0);
    gq.push_back(3'b001);
    cyc();
    req[0] = 0;
    drv(1, 1, 0, 11'h2, '0);
    gq.push_back(3'b010);
    cyc();
    drv(1, 1, 1, 11'h3, 32'h99);
    drv(2, 1, 0, 11'h4, '0);
    gq.push_back(3'b010);
    @(negedge clk);
    chk("t4_write_wins", s_write, 1'b1);
    cyc();
    req[1] = 0;
    s_rvalid = 1;
    s_rdata = 32'hB0;
    rq.push_back(rsp(3'b001, 32'hB0, 2'b00, 0));
    @(negedge clk);
    chk("t4_masked_req", s_req, 1'b0);
    cyc();
    s_rvalid = 0;
    gq.push_back(3'b100);
    @(negedge clk);
    chk("t4_unblocked_addr", s_addr, 11'h4);
    cyc();
    idle();
    s_rvalid = 1;
    s_rdata = 32'hC1;
    rq.push_back(rsp(3'b010, 32'hC1, 2'b00, 0));
    cyc();
    s_rdata = 32'hD2;
    s_err = 2'b01;
    rq.push_back(rsp(3'b100, 32'hD2, 2'b01, 0));
    cyc();
    idle();
    cyc();
    // response ordering
    do_reset();
    s_gnt = 1;
    drv(2, 1, 0, 11'h50, '0);
    gq.push_back(3'b100);
    cyc();
    req[2] = 0;
    drv(0, 1, 0, 11'h51, '0);
    gq.push_back(3'b001);
    cyc();
    idle();
    s_rvalid = 1;
    s_rdata = 32'h2222;
    rq.push_back(rsp(3'b100, 32'h2222, 2'b00, 0));
    cyc();
    s_rdata = 32'h3333;
    rq.push_back(rsp(3'b001, 32'h3333, 2'b00, 0));
    cyc();
    // unexpected rvalid on empty FIFO
    s_rdata = 32'h4444;
    rq.push_back(rsp(3'b000, 32'h4444, 2'b00, 1));
    cyc();
    idle();
    cyc();
    // reset discards outstanding read
    s_gnt = 1;
    drv(0, 1, 0, 11'h60, '0);
    gq.push_back(3'b001);
    cyc();
    do_reset();
    s_rvalid = 1;
    s_rdata = 32'h5555;
    rq.push_back(rsp(3'b000, 32'h5555, 2'b00, 1));
    cyc();
    idle();
    cyc();
    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
